complex_mag_engine: RTL and testbench

COMPLEX_MAG_ENGINE -- requirements
Module: complex_mag_engine

---
 rtl/complex_mag_engine_if.sv | 35 +++
 rtl/complex_mag_engine.sv | 211 +++++++++++++++++++++
 tb/tb_complex_mag_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/complex_mag_engine_if.sv
// Sample stream in, magnitude stream out, plus the per-frame peak report.
// The engine takes the slave side; whatever feeds and drains it takes the master side.
interface complex_mag_engine_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
);
    logic signed [DATA_WIDTH-1:0] s_i_in;
    logic signed [DATA_WIDTH-1:0] s_q_in;
    logic                         s_valid_in;
    logic                         s_last_in;
    logic [1:0]                   mode_in;
    logic                         s_ready_out;

    logic [DATA_WIDTH:0]          m_mag_out;
    logic [INDEX_WIDTH-1:0]       m_index_out;
    logic                         m_last_out;
    logic                         m_valid_out;
    logic                         m_ready_in;

    logic [DATA_WIDTH:0]          peak_mag_out;
    logic [INDEX_WIDTH-1:0]       peak_index_out;
    logic                         peak_valid_out;

    modport slave (
        input  s_i_in, s_q_in, s_valid_in, s_last_in, mode_in, m_ready_in,
        output s_ready_out, m_mag_out, m_index_out, m_last_out, m_valid_out,
               peak_mag_out, peak_index_out, peak_valid_out
    );

    modport master (
        output s_i_in, s_q_in, s_valid_in, s_last_in, mode_in, m_ready_in,
        input  s_ready_out, m_mag_out, m_index_out, m_last_out, m_valid_out,
               peak_mag_out, peak_index_out, peak_valid_out
    );
endinterface

// File: rtl/complex_mag_engine.sv
// Three-stage I/Q magnitude estimator (abs -> min/max -> combine) with a
// per-frame peak tracker. The whole pipeline stalls together on output back-pressure.
module complex_mag_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    complex_mag_engine_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = INDEX_WIDTH;

    // Two's-complement abs into DW unsigned bits; the most negative input maps to 2^(DW-1).
    function automatic logic [DW-1:0] abs_u(input logic [DW-1:0] x);
        return x[DW-1] ? ((~x) + DW'(1)) : x;
    endfunction

    logic en;
    logic accept;

    logic [IW-1:0] idx_q, idx_d;

    logic          v1_q, v1_d;
    logic [DW-1:0] ai1_q, ai1_d;
    logic [DW-1:0] aq1_q, aq1_d;
    logic [IW-1:0] idx1_q, idx1_d;
    logic          last1_q, last1_d;
    logic [1:0]    mode1_q, mode1_d;

    logic          v2_q, v2_d;
    logic [DW-1:0] max2_q, max2_d;
    logic [DW-1:0] min2_q, min2_d;
    logic [IW-1:0] idx2_q, idx2_d;
    logic          last2_q, last2_d;
    logic [1:0]    mode2_q, mode2_d;

    logic          mv_q, mv_d;
    logic [DW:0]   mag_q, mag_d;
    logic [IW-1:0] midx_q, midx_d;
    logic          mlast_q, mlast_d;

    logic          in_frame_q, in_frame_d;
    logic [DW:0]   trk_mag_q, trk_mag_d;
    logic [IW-1:0] trk_idx_q, trk_idx_d;
    logic [DW:0]   pk_mag_q, pk_mag_d;
    logic [IW-1:0] pk_idx_q, pk_idx_d;
    logic          pv_q, pv_d;

    logic          hs;
    logic [DW:0]   ext_max;
    logic [DW:0]   ext_min;
    logic [DW:0]   combined;
    logic [DW:0]   cand_mag;
    logic [IW-1:0] cand_idx;

    assign en              = !mv_q || bus.m_ready_in;
    assign accept          = bus.s_valid_in && en;
    assign bus.s_ready_out = en;
    assign hs              = mv_q && bus.m_ready_in;

    assign ext_max = {1'b0, max2_q};
    assign ext_min = {1'b0, min2_q};

    always_comb begin
        combined = ext_max;
        case (mode2_q)
            2'd0:    combined = ext_max + (ext_min >> 2);
            2'd1:    combined = ext_max + (ext_min >> 2) + (ext_min >> 3);
            2'd2:    combined = ext_max;
            default: combined = ext_max + ext_min;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = bus.s_last_in ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        v1_d    = v1_q;
        ai1_d   = ai1_q;
        aq1_d   = aq1_q;
        idx1_d  = idx1_q;
        last1_d = last1_q;
        mode1_d = mode1_q;
        v2_d    = v2_q;
        max2_d  = max2_q;
        min2_d  = min2_q;
        idx2_d  = idx2_q;
        last2_d = last2_q;
        mode2_d = mode2_q;
        mv_d    = mv_q;
        mag_d   = mag_q;
        midx_d  = midx_q;
        mlast_d = mlast_q;
        if (en) begin
            v1_d    = bus.s_valid_in;
            ai1_d   = abs_u(bus.s_i_in);
            aq1_d   = abs_u(bus.s_q_in);
            idx1_d  = idx_q;
            last1_d = bus.s_last_in;
            mode1_d = bus.mode_in;

            v2_d    = v1_q;
            max2_d  = (ai1_q >= aq1_q) ? ai1_q : aq1_q;
            min2_d  = (ai1_q >= aq1_q) ? aq1_q : ai1_q;
            idx2_d  = idx1_q;
            last2_d = last1_q;
            mode2_d = mode1_q;

            mv_d    = v2_q;
            mag_d   = combined;
            midx_d  = idx2_q;
            mlast_d = last2_q;
        end
    end

    // First beat of a frame loads unconditionally; afterwards only a strictly larger value wins.
    always_comb begin
        cand_mag = trk_mag_q;
        cand_idx = trk_idx_q;
        if (!in_frame_q || (mag_q > trk_mag_q)) begin
            cand_mag = mag_q;
            cand_idx = midx_q;
        end
    end

    always_comb begin
        in_frame_d = in_frame_q;
        trk_mag_d  = trk_mag_q;
        trk_idx_d  = trk_idx_q;
        pk_mag_d   = pk_mag_q;
        pk_idx_d   = pk_idx_q;
        pv_d       = 1'b0;
        if (hs) begin
            trk_mag_d = cand_mag;
            trk_idx_d = cand_idx;
            if (mlast_q) begin
                in_frame_d = 1'b0;
                pk_mag_d   = cand_mag;
                pk_idx_d   = cand_idx;
                pv_d       = 1'b1;
            end else begin
                in_frame_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_q      <= '0;
            v1_q       <= 1'b0;
            ai1_q      <= '0;
            aq1_q      <= '0;
            idx1_q     <= '0;
            last1_q    <= 1'b0;
            mode1_q    <= '0;
            v2_q       <= 1'b0;
            max2_q     <= '0;
            min2_q     <= '0;
            idx2_q     <= '0;
            last2_q    <= 1'b0;
            mode2_q    <= '0;
            mv_q       <= 1'b0;
            mag_q      <= '0;
            midx_q     <= '0;
            mlast_q    <= 1'b0;
            in_frame_q <= 1'b0;
            trk_mag_q  <= '0;
            trk_idx_q  <= '0;
            pk_mag_q   <= '0;
            pk_idx_q   <= '0;
            pv_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            v1_q       <= v1_d;
            ai1_q      <= ai1_d;
            aq1_q      <= aq1_d;
            idx1_q     <= idx1_d;
            last1_q    <= last1_d;
            mode1_q    <= mode1_d;
            v2_q       <= v2_d;
            max2_q     <= max2_d;
            min2_q     <= min2_d;
            idx2_q     <= idx2_d;
            last2_q    <= last2_d;
            mode2_q    <= mode2_d;
            mv_q       <= mv_d;
            mag_q      <= mag_d;
            midx_q     <= midx_d;
            mlast_q    <= mlast_d;
            in_frame_q <= in_frame_d;
            trk_mag_q  <= trk_mag_d;
            trk_idx_q  <= trk_idx_d;
            pk_mag_q   <= pk_mag_d;
            pk_idx_q   <= pk_idx_d;
            pv_q       <= pv_d;
        end
    end

    assign bus.m_valid_out    = mv_q;
    assign bus.m_mag_out      = mag_q;
    assign bus.m_index_out    = midx_q;
    assign bus.m_last_out     = mlast_q;
    assign bus.peak_mag_out   = pk_mag_q;
    assign bus.peak_index_out = pk_idx_q;
    assign bus.peak_valid_out = pv_q;
endmodule

// File: tb/tb_complex_mag_engine.sv
// Directed bench for complex_mag_engine at DATA_WIDTH=16, INDEX_WIDTH=6.
module tb_complex_mag_engine;
    localparam int DW = 16;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    complex_mag_engine_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) u ();

    complex_mag_engine #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (u.slave)
    );

    typedef struct {
        int mag;
        int idx;
        bit last;
    } beat_t;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    got_rd = 0;
    int    exp_rd = 0;
    int    pk_cnt = 0;
    int    pk_long = 0;
    bit    pv_prev = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (u.m_valid_out && u.m_ready_in)
                got_q.push_back('{int'(u.m_mag_out), int'(u.m_index_out), u.m_last_out});
            if (u.peak_valid_out) begin
                pk_cnt++;
                if (pv_prev) pk_long++;
            end
        end
        pv_prev = u.peak_valid_out;
    end

    task automatic send(input int i, input int q, input int mode, input bit last,
                        input int emag, input int eidx);
        bit acc;
        u.s_i_in     = i[DW-1:0];
        u.s_q_in     = q[DW-1:0];
        u.mode_in    = mode[1:0];
        u.s_last_in  = last;
        u.s_valid_in = 1'b1;
        exp_q.push_back('{emag, eidx, last});
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = u.s_ready_out;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        u.s_valid_in = 1'b0;
        u.s_last_in  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 100 && (got_q.size() - got_rd) < (exp_q.size() - exp_rd); c++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size() - got_rd, exp_q.size() - exp_rd);
        while (exp_rd < exp_q.size() && got_rd < got_q.size()) begin
            chk({tag, "_mag"},  got_q[got_rd].mag,  exp_q[exp_rd].mag);
            chk({tag, "_idx"},  got_q[got_rd].idx,  exp_q[exp_rd].idx);
            chk({tag, "_last"}, got_q[got_rd].last, exp_q[exp_rd].last);
            got_rd++;
            exp_rd++;
        end
        got_rd = got_q.size();
        exp_rd = exp_q.size();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"},    u.s_ready_out, 1);
        chk({tag, "_m_valid"},    u.m_valid_out, 0);
        chk({tag, "_m_mag"},      u.m_mag_out, 0);
        chk({tag, "_m_index"},    u.m_index_out, 0);
        chk({tag, "_m_last"},     u.m_last_out, 0);
        chk({tag, "_peak_valid"}, u.peak_valid_out, 0);
        chk({tag, "_peak_mag"},   u.peak_mag_out, 0);
        chk({tag, "_peak_index"}, u.peak_index_out, 0);
    endtask

    initial begin
        int pk0;
        int held_mag;
        int held_idx;
        u.s_i_in     = '0;
        u.s_q_in     = '0;
        u.s_valid_in = 1'b0;
        u.s_last_in  = 1'b0;
        u.mode_in    = '0;
        u.m_ready_in = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency and single-beat frame: |300 - j400| mode 0 -> 400 + 75
        pk0 = pk_cnt;
        send(300, -400, 0, 1, 475, 0);
        chk("lat_edge1_valid", u.m_valid_out, 0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", u.m_valid_out, 0);
        @(posedge clk); #1;
        chk("lat_edge3_valid", u.m_valid_out, 1);
        chk("lat_edge3_mag", u.m_mag_out, 475);
        chk("lat_pv_before_hs", u.peak_valid_out, 0);
        @(posedge clk); #1;
        chk("lat_pv_after_hs", u.peak_valid_out, 1);
        chk("single_peak_mag", u.peak_mag_out, 475);
        chk("single_peak_idx", u.peak_index_out, 0);
        @(posedge clk); #1;
        chk("lat_pv_dropped", u.peak_valid_out, 0);
        drain("lat");
        chk("lat_pulses", pk_cnt - pk0, 1);

        // Most-negative I/Q in every mode
        pk0 = pk_cnt;
        send(-32768, -32768, 0, 0, 40960, 0);
        send(-32768, -32768, 1, 0, 45056, 1);
        send(-32768, -32768, 2, 0, 32768, 2);
        send(-32768, -32768, 3, 1, 65536, 3);
        drain("modes");
        chk("modes_peak_mag", u.peak_mag_out, 65536);
        chk("modes_peak_idx", u.peak_index_out, 3);
        chk("modes_pulses", pk_cnt - pk0, 1);

        // Frame 10, 50, 50, 20: tie keeps the first index
        pk0 = pk_cnt;
        send(10, 0, 2, 0, 10, 0);
        send(0, -50, 2, 0, 50, 1);
        send(50, -50, 2, 0, 50, 2);
        send(-20, 5, 2, 1, 20, 3);
        drain("frame");
        chk("frame_peak_mag", u.peak_mag_out, 50);
        chk("frame_peak_idx", u.peak_index_out, 1);
        chk("frame_pulses", pk_cnt - pk0, 1);

        // Continuous stream with a 5-cycle output stall
        pk0 = pk_cnt;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(100 + k, -k, 2, (k == 7), 100 + k, k);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                u.m_ready_in = 1'b0;
                held_mag = int'(u.m_mag_out);
                held_idx = int'(u.m_index_out);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_valid", u.m_valid_out, 1);
                    chk("stall_mag", u.m_mag_out, held_mag);
                    chk("stall_idx", u.m_index_out, held_idx);
                    chk("stall_s_ready", u.s_ready_out, 0);
                    @(posedge clk);
                    #1;
                end
                u.m_ready_in = 1'b1;
            end
        join
        drain("stall");
        chk("stall_peak_mag", u.peak_mag_out, 107);
        chk("stall_peak_idx", u.peak_index_out, 7);
        chk("stall_pulses", pk_cnt - pk0, 1);

        // 70 beats with no last: index wraps 63 -> 0, no peak report
        pk0 = pk_cnt;
        for (int k = 0; k < 70; k++)
            send(k, 0, 2, 0, k, k % 64);
        drain("wrap");
        chk("wrap_pulses", pk_cnt - pk0, 0);
        chk("wrap_peak_kept", u.peak_mag_out, 107);

        // Reset with three large beats in flight mid-frame
        send(1000, 5, 2, 0, 1000, 6);
        send(1000, 5, 2, 0, 1000, 7);
        send(1000, 5, 2, 0, 1000, 8);
        chk("prerst_valid", u.m_valid_out, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_rd = got_q.size();
        exp_rd = exp_q.size();
        pk0 = pk_cnt;
        send(5, 0, 2, 0, 5, 0);
        send(7, 0, 2, 1, 7, 1);
        drain("postrst");
        chk("postrst_peak_mag", u.peak_mag_out, 7);
        chk("postrst_peak_idx", u.peak_index_out, 1);
        chk("postrst_pulses", pk_cnt - pk0, 1);

        chk("peak_pulse_width", pk_long, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
